// File: rtl/swt16_pkg.sv
// -----------------------------------------------------------------------------
// swt16_pkg
// Shared definitions for the PMEM boot loader path.
//   loader_state_t       : loader FSM state encoding (also exported for debug)
//   PMEM_BYTES_PER_WORD  : PMEM words are assembled from this many bytes
//   PC_INCREMENT_DEFAULT : byte-address step between consecutive instructions
// -----------------------------------------------------------------------------
package swt16_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LO     = 3'd1,
      ST_HI     = 3'd2,
      ST_WR     = 3'd3,
      ST_DONE   = 3'd4,
      ST_CHK_LO = 3'd5,
      ST_CHK_HI = 3'd6,
      ST_ERR    = 3'd7
   } loader_state_t;

   localparam int PMEM_BYTES_PER_WORD  = 2;
   localparam int PC_INCREMENT_DEFAULT = 2;

endpackage

// File: rtl/pmem_loader_word_asm.sv
// -----------------------------------------------------------------------------
// pmem_loader_word_asm
// Byte-lane register that assembles a 16-bit word from two bytes, low byte
// first. Used both for program words and for the checksum trailer.
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   lo_en     in   capture data into the low lane this cycle
//   hi_en     in   capture data into the high lane this cycle
//   data      in   byte to capture
//   word_next out  the word as it stands after this cycle's capture; while
//                  hi_en is high it already carries the incoming high byte,
//                  so the owner can consume the complete word in the same
//                  cycle the second byte arrives
// -----------------------------------------------------------------------------
module pmem_loader_word_asm
   import swt16_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        lo_en,
   input  logic        hi_en,
   input  logic [7:0]  data,
   output logic [15:0] word_next
);

   logic [7:0] lo_q;
   logic [7:0] hi_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lo_q <= 8'h00;
         hi_q <= 8'h00;
      end else begin
         if (lo_en) lo_q <= data;
         if (hi_en) hi_q <= data;
      end
   end

   always_comb begin
      word_next = {hi_q, lo_q};
      if (hi_en) word_next = {data, lo_q};
   end

endmodule

// File: rtl/pmem_loader.sv
// -----------------------------------------------------------------------------
// pmem_loader
// Streams a program image from a byte link into PMEM and holds the core in
// reset until the whole image has been written.
//
// Optional feature: define PMEM_LOADER_CHECKSUM_EN to require a 2-byte
// trailer (low byte first) equal to the 16-bit sum of all written words.
//
// Handshake: a byte moves on every rising edge where in_byte_valid and
// out_byte_ready are both high. out_byte_ready depends only on the state, so
// the source may raise or drop valid at any time without losing a byte.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   in_start       in   start pulse, honoured only in IDLE, DONE or ERR
//   in_base_addr   in   first PMEM byte address (sampled with in_start)
//   in_num_words   in   image length in words (sampled with in_start)
//   in_byte        in   byte data
//   in_byte_valid  in   byte valid
//   out_byte_ready out  loader accepts a byte this cycle
//   out_pmem_wr_en out  PMEM write strobe, one cycle per word
//   out_pmem_addr  out  PMEM write address (holds between writes)
//   out_pmem_word  out  PMEM write data (holds between writes)
//   out_cpu_hold   out  1 = keep the core in reset
//   out_done       out  image loaded (level)
//   out_error      out  checksum mismatch, held until the next start
//   out_state      out  current FSM state (loader_state_t encoding)
// -----------------------------------------------------------------------------
module pmem_loader
   import swt16_pkg::*;
#(
   parameter int PMEM_ADDR_WIDTH = 12,
   parameter int PMEM_WORD_WIDTH = 8 * PMEM_BYTES_PER_WORD,
   parameter int PC_INCREMENT    = PC_INCREMENT_DEFAULT,
   parameter int CNT_WIDTH       = 12
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_start,
   input  logic [PMEM_ADDR_WIDTH-1:0] in_base_addr,
   input  logic [CNT_WIDTH-1:0]       in_num_words,
   input  logic [7:0]                 in_byte,
   input  logic                       in_byte_valid,
   output logic                       out_byte_ready,
   output logic                       out_pmem_wr_en,
   output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_addr,
   output logic [PMEM_WORD_WIDTH-1:0] out_pmem_word,
   output logic                       out_cpu_hold,
   output logic                       out_done,
   output logic                       out_error,
   output logic [2:0]                 out_state
);

   loader_state_t state_q;
   loader_state_t state_d;
   loader_state_t after_last;

   logic [PMEM_ADDR_WIDTH-1:0] addr_q;
   logic [CNT_WIDTH-1:0]       cnt_q;
   logic [PMEM_ADDR_WIDTH-1:0] pmem_addr_q;
   logic [PMEM_WORD_WIDTH-1:0] pmem_word_q;
   logic [15:0]                asm_word;
   logic                       xfer;
   logic                       start_take;
   logic                       lo_en;
   logic                       hi_en;

`ifdef PMEM_LOADER_CHECKSUM_EN
   logic [15:0] sum_q;
   logic        trailer_ok;
   assign after_last = ST_CHK_LO;
   assign trailer_ok = (asm_word == sum_q);
`else
   assign after_last = ST_DONE;
`endif

   assign xfer       = in_byte_valid && out_byte_ready;
   assign start_take = in_start &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
   assign lo_en      = xfer && ((state_q == ST_LO) || (state_q == ST_CHK_LO));
   assign hi_en      = xfer && ((state_q == ST_HI) || (state_q == ST_CHK_HI));

   pmem_loader_word_asm u_word_asm (
      .clock     (clock),
      .reset     (reset),
      .lo_en     (lo_en),
      .hi_en     (hi_en),
      .data      (in_byte),
      .word_next (asm_word)
   );

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (in_start) state_d = (in_num_words == '0) ? after_last : ST_LO;
         end
         ST_LO:     if (xfer) state_d = ST_HI;
         ST_HI:     if (xfer) state_d = ST_WR;
         // cnt_q still holds the pre-decrement count here, so 1 means last word.
         ST_WR:     state_d = (cnt_q == CNT_WIDTH'(1)) ? after_last : ST_LO;
`ifdef PMEM_LOADER_CHECKSUM_EN
         ST_CHK_LO: if (xfer) state_d = ST_CHK_HI;
         ST_CHK_HI: if (xfer) state_d = trailer_ok ? ST_DONE : ST_ERR;
`endif
         default:   state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      out_byte_ready = 1'b0;
      out_pmem_wr_en = 1'b0;
      out_cpu_hold   = 1'b1;
      out_done       = 1'b0;
      out_error      = 1'b0;
      case (state_q)
         ST_LO, ST_HI, ST_CHK_LO, ST_CHK_HI: out_byte_ready = 1'b1;
         ST_WR:   out_pmem_wr_en = 1'b1;
         ST_DONE: begin
            out_cpu_hold = 1'b0;
            out_done     = 1'b1;
         end
`ifdef PMEM_LOADER_CHECKSUM_EN
         ST_ERR:  out_error = 1'b1;
`endif
         default: ;
      endcase
   end

   assign out_pmem_addr = pmem_addr_q;
   assign out_pmem_word = pmem_word_q;
   assign out_state     = state_q;

   // ---------------------------------------------------------------- datapath
   // The write address/data are registered when the high byte arrives so
   // they are stable through the WR cycle and hold afterwards, even while
   // the next word's low byte is being captured.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q      <= '0;
         cnt_q       <= '0;
         pmem_addr_q <= '0;
         pmem_word_q <= '0;
      end else begin
         if (start_take) begin
            addr_q <= in_base_addr;
            cnt_q  <= in_num_words;
         end
         if ((state_q == ST_HI) && xfer) begin
            pmem_addr_q <= addr_q;
            pmem_word_q <= asm_word;
         end
         if (state_q == ST_WR) begin
            // Wraps modulo 2^PMEM_ADDR_WIDTH by truncation.
            addr_q <= addr_q + PMEM_ADDR_WIDTH'(PC_INCREMENT);
            cnt_q  <= cnt_q - CNT_WIDTH'(1);
         end
      end
   end

`ifdef PMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sum_q <= 16'h0000;
      end else if (start_take) begin
         sum_q <= 16'h0000;
      end else if (state_q == ST_WR) begin
         sum_q <= sum_q + pmem_word_q;
      end
   end
`endif

endmodule

// File: tb/tb_pmem_loader.sv
module tb_pmem_loader;

   logic        clock;
   logic        reset;
   logic        in_start;
   logic [11:0] in_base_addr;
   logic [11:0] in_num_words;
   logic [7:0]  in_byte;
   logic        in_byte_valid;
   logic        out_byte_ready;
   logic        out_pmem_wr_en;
   logic [11:0] out_pmem_addr;
   logic [15:0] out_pmem_word;
   logic        out_cpu_hold;
   logic        out_done;
   logic        out_error;
   logic [2:0]  out_state;

   pmem_loader dut (
      .clock          (clock),
      .reset          (reset),
      .in_start       (in_start),
      .in_base_addr   (in_base_addr),
      .in_num_words   (in_num_words),
      .in_byte        (in_byte),
      .in_byte_valid  (in_byte_valid),
      .out_byte_ready (out_byte_ready),
      .out_pmem_wr_en (out_pmem_wr_en),
      .out_pmem_addr  (out_pmem_addr),
      .out_pmem_word  (out_pmem_word),
      .out_cpu_hold   (out_cpu_hold),
      .out_done       (out_done),
      .out_error      (out_error),
      .out_state      (out_state)
   );

   // clock / watchdog
   initial clock = 1'b0;
   always #5 clock = ~clock;

   int vec_cnt = 0;
   int err_cnt = 0;
   int wr_seen = 0;
   logic [27:0] exp_q[$];   // {addr, word}

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every write strobe must match the head of the expected queue
   always @(negedge clock) begin
      if (reset && out_pmem_wr_en) begin
         wr_seen++;
         check("ready_during_wr", {31'd0, out_byte_ready}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            logic [27:0] e;
            e = exp_q.pop_front();
            check("wr_addr", {20'd0, out_pmem_addr}, {20'd0, e[27:16]});
            check("wr_word", {16'd0, out_pmem_word}, {16'd0, e[15:0]});
         end
      end
   end

   // driver tasks (called at posedge+1)
   task automatic send_byte(input logic [7:0] b, input bit gap);
      if (gap) begin
         in_byte_valid = 1'b0;
         @(posedge clock); #1;
      end
      in_byte       = b;
      in_byte_valid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         if (out_byte_ready) begin
            @(posedge clock); #1;
            in_byte_valid = 1'b0;
            return;
         end
         @(posedge clock); #1;
      end
      in_byte_valid = 1'b0;
      check("byte_ready_timeout", 32'd1, 32'd0);
   endtask

   task automatic pulse_start(input logic [11:0] base, input logic [11:0] n);
      in_start     = 1'b1;
      in_base_addr = base;
      in_num_words = n;
      @(posedge clock); #1;
      in_start = 1'b0;
   endtask

   typedef struct {
      logic [11:0] base;
      logic [11:0] num;     // 0..2
      logic [31:0] bytes;   // {b3,b2,b1,b0}, b0 sent first
      bit          toggle;
      logic [23:0] ea;      // {addr1, addr0}
      logic [31:0] ew;      // {word1, word0}
   } vec_t;

   vec_t vecs[5];

   task automatic run_vec(input int idx, input vec_t v);
      logic [15:0] sum;
      string tag;
      tag = $sformatf("v%0d", idx);
      sum = 16'h0000;
      wr_seen = 0;
      for (int i = 0; i < int'(v.num); i++) begin
         exp_q.push_back({v.ea[12*i +: 12], v.ew[16*i +: 16]});
         sum = sum + v.ew[16*i +: 16];
      end
      pulse_start(v.base, v.num);
      check({tag, "_done_clr"}, {31'd0, out_done}, {31'd0, (v.num == 0)
`ifdef PMEM_LOADER_CHECKSUM_EN
         && 1'b0
`endif
         });
      for (int i = 0; i < 2 * int'(v.num); i++) send_byte(v.bytes[8*i +: 8], v.toggle);
      if (v.num != 0) begin
         check({tag, "_wr_en"}, {31'd0, out_pmem_wr_en}, 32'd1);
         @(posedge clock); #1;
      end
`ifdef PMEM_LOADER_CHECKSUM_EN
      send_byte(sum[7:0], v.toggle);
      send_byte(sum[15:8], v.toggle);
`endif
      check({tag, "_done"},  {31'd0, out_done},       32'd1);
      check({tag, "_hold"},  {31'd0, out_cpu_hold},   32'd0);
      check({tag, "_ready"}, {31'd0, out_byte_ready}, 32'd0);
      check({tag, "_error"}, {31'd0, out_error},      32'd0);
      check({tag, "_nwr"},   wr_seen,                 {20'd0, v.num});
      check({tag, "_q"},     exp_q.size(),            32'd0);
      if (v.num != 0) begin
         repeat (2) @(posedge clock); #1;
         check({tag, "_addr_hold"}, {20'd0, out_pmem_addr}, {20'd0, v.ea[12*(v.num-1) +: 12]});
         check({tag, "_word_hold"}, {16'd0, out_pmem_word}, {16'd0, v.ew[16*(v.num-1) +: 16]});
      end
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b0; in_start = 1'b0; in_base_addr = '0; in_num_words = '0;
      in_byte = '0; in_byte_valid = 1'b0;

      vecs[0] = '{12'h010, 12'd2, 32'hABCD1234, 1'b0, {12'h012, 12'h010}, {16'hABCD, 16'h1234}};
      vecs[1] = '{12'h010, 12'd2, 32'hABCD1234, 1'b1, {12'h012, 12'h010}, {16'hABCD, 16'h1234}};
      vecs[2] = '{12'hFFE, 12'd2, 32'hBEEF5678, 1'b0, {12'h000, 12'hFFE}, {16'hBEEF, 16'h5678}};
      vecs[3] = '{12'h020, 12'd2, 32'h00020001, 1'b0, {12'h022, 12'h020}, {16'h0002, 16'h0001}};
      vecs[4] = '{12'h055, 12'd0, 32'h00000000, 1'b0, 24'h0,               32'h0};

      // reset state
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); #1;
      check("rst_hold",  {31'd0, out_cpu_hold},   32'd1);
      check("rst_done",  {31'd0, out_done},       32'd0);
      check("rst_ready", {31'd0, out_byte_ready}, 32'd0);
      check("rst_wr_en", {31'd0, out_pmem_wr_en}, 32'd0);
      check("rst_error", {31'd0, out_error},      32'd0);
      check("rst_addr",  {20'd0, out_pmem_addr},  32'd0);
      check("rst_word",  {16'd0, out_pmem_word},  32'd0);

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // restart from DONE: hold reasserted, done cleared on the next cycle,
      // and a start pulse during LO is ignored
      exp_q.push_back({12'h300, 16'h2211});
      wr_seen = 0;
      pulse_start(12'h300, 12'd1);
      check("restart_done", {31'd0, out_done},     32'd0);
      check("restart_hold", {31'd0, out_cpu_hold}, 32'd1);
      pulse_start(12'h400, 12'd5);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      @(posedge clock); #1;
`ifdef PMEM_LOADER_CHECKSUM_EN
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
`endif
      check("ign_start_done", {31'd0, out_done}, 32'd1);
      check("ign_start_nwr",  wr_seen,           32'd1);
      exp_q.delete();

`ifdef PMEM_LOADER_CHECKSUM_EN
      // wrong trailer -> ERR, then recovery via start
      exp_q.push_back({12'h020, 16'h0001});
      exp_q.push_back({12'h022, 16'h0002});
      pulse_start(12'h020, 12'd2);
      send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0); send_byte(8'h00, 1'b0);
      @(posedge clock); #1;
      send_byte(8'h04, 1'b0); send_byte(8'h00, 1'b0);
      repeat (2) @(posedge clock); #1;
      check("err_error", {31'd0, out_error},    32'd1);
      check("err_hold",  {31'd0, out_cpu_hold}, 32'd1);
      check("err_done",  {31'd0, out_done},     32'd0);
      pulse_start(12'h000, 12'd0);
      check("err_clr", {31'd0, out_error}, 32'd0);
      send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
      check("err_recover_done", {31'd0, out_done}, 32'd1);
      exp_q.delete();
`endif

      // asynchronous reset while waiting for the high byte: no write issued
      wr_seen = 0;
      pulse_start(12'h040, 12'd1);
      send_byte(8'h5A, 1'b0);
      #2 reset = 1'b0;
      #1;
      check("amid_hold",  {31'd0, out_cpu_hold},   32'd1);
      check("amid_ready", {31'd0, out_byte_ready}, 32'd0);
      check("amid_wr_en", {31'd0, out_pmem_wr_en}, 32'd0);
      check("amid_state", {29'd0, out_state},      32'd0);
      in_byte = 8'hA5; in_byte_valid = 1'b1;
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (4) @(posedge clock); #1;
      in_byte_valid = 1'b0;
      check("amid_nwr",   wr_seen,                 32'd0);
      check("amid_idle",  {31'd0, out_cpu_hold},   32'd1);
      check("amid_ready2",{31'd0, out_byte_ready}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
